// File: rtl/cnn_pkg.sv
// Shared coprocessor definitions: cfg register map and stream geometry helpers.
`timescale 1ns/1ps
package cnn_pkg;

    localparam logic [4:0] CFG_LAYER_ADDR  = 5'd0;
    localparam logic [4:0] CFG_KERNEL_ADDR = 5'd4;
    localparam logic [4:0] CFG_IMG_ADDR    = 5'd8;
    localparam logic [4:0] CFG_LEN_ADDR    = 5'd20;

    function automatic int rlt_ratio(input int rlt_width, input int str_width);
        return rlt_width / str_width;
    endfunction

endpackage

// File: rtl/rlt_assemble.sv
// Gathers RATIO narrow beats (LS slice first) into one wide word, pulsing word_val on the closing beat.
// Only the closing beat honours stall; flush drops the partial word and any closing beat in that cycle.
`timescale 1ns/1ps
module rlt_assemble #(
    parameter int STR_WIDTH = 64,
    parameter int RATIO     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [STR_WIDTH-1:0]         beat,
    input  logic                         beat_val,
    output logic                         beat_rdy,
    input  logic                         stall,
    output logic [RATIO*STR_WIDTH-1:0]   word,
    output logic                         word_val
);

    localparam int CNT_W = $clog2(RATIO);

    logic [CNT_W-1:0]                beat_cnt;
    logic [RATIO-2:0][STR_WIDTH-1:0] slices;
    logic                            closing;
    logic                            take;

    assign closing  = (beat_cnt == CNT_W'(RATIO - 1));
    assign beat_rdy = rst & ~(closing & stall);
    assign take     = beat_val & beat_rdy;
    assign word     = {beat, slices};
    assign word_val = take & closing & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            slices   <= '0;
        end else if (flush) begin
            beat_cnt <= '0;
        end else if (take) begin
            if (closing) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
                for (int i = 0; i < RATIO - 1; i++) begin
                    if (beat_cnt == CNT_W'(i)) slices[i] <= beat;
                end
            end
        end
    end

endmodule

// File: rtl/rlt_unpack.sv
// Host-side result receiver: reassembles narrow beats into full words, frames them with result_last.
// Word appears the cycle after its closing beat; a held output word stalls only the next closing beat.
`timescale 1ns/1ps
module rlt_unpack #(
    parameter int                    CFG_DWIDTH    = 32,
    parameter int                    CFG_AWIDTH    = 5,
    parameter logic [CFG_AWIDTH-1:0] CFG_LEN_ADDR  = cnn_pkg::CFG_LEN_ADDR,
    parameter int                    STR_RLT_WIDTH = 64,
    parameter int                    IMG_WIDTH     = 16,
    parameter int                    DEPTH_NB      = 16,
    parameter int                    LEN_WIDTH     = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic [STR_RLT_WIDTH-1:0]      str_rlt_bus,
    input  logic                          str_rlt_val,
    output logic                          str_rlt_rdy,
    output logic [IMG_WIDTH*DEPTH_NB-1:0] result_bus,
    output logic                          result_last,
    output logic                          result_val,
    input  logic                          result_rdy
);

    import cnn_pkg::rlt_ratio;

    localparam int RLT_WIDTH = IMG_WIDTH * DEPTH_NB;
    localparam int RATIO     = rlt_ratio(RLT_WIDTH, STR_RLT_WIDTH);

    if ((RLT_WIDTH % STR_RLT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
        $error("rlt_unpack: result width must be an integer multiple (>=2) of the beat width");
    end
    if (LEN_WIDTH > CFG_DWIDTH) begin : g_bad_len
        $error("rlt_unpack: LEN_WIDTH exceeds CFG_DWIDTH");
    end
    if (CFG_DWIDTH > LEN_WIDTH) begin : g_cfg_upper
        logic unused_cfg_upper;
        assign unused_cfg_upper = ^cfg_data[CFG_DWIDTH-1:LEN_WIDTH];
    end

    logic                 cfg_len_wr;
    logic                 stall;
    logic [RLT_WIDTH-1:0] word;
    logic                 word_val;
    logic [LEN_WIDTH-1:0] frame_len;
    logic [LEN_WIDTH-1:0] word_cnt;
    logic                 is_last;

    assign cfg_len_wr = cfg_valid && (cfg_addr == CFG_LEN_ADDR);
    assign stall      = result_val & ~result_rdy;
    assign is_last    = (frame_len != '0) && (word_cnt == frame_len - 1'b1);

    rlt_assemble #(
        .STR_WIDTH (STR_RLT_WIDTH),
        .RATIO     (RATIO)
    ) u_assemble (
        .clk      (clk),
        .rst      (rst),
        .flush    (cfg_len_wr),
        .beat     (str_rlt_bus),
        .beat_val (str_rlt_val),
        .beat_rdy (str_rlt_rdy),
        .stall    (stall),
        .word     (word),
        .word_val (word_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_bus  <= '0;
            result_val  <= 1'b0;
            result_last <= 1'b0;
        end else if (word_val) begin
            result_bus  <= word;
            result_val  <= 1'b1;
            result_last <= is_last;
        end else if (result_val && result_rdy) begin
            result_val  <= 1'b0;
            result_last <= 1'b0;
        end
    end

    // A zero length disables framing, so the counter parks at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_len <= '0;
            word_cnt  <= '0;
        end else if (cfg_len_wr) begin
            frame_len <= cfg_data[LEN_WIDTH-1:0];
            word_cnt  <= '0;
        end else if (word_val) begin
            word_cnt  <= (frame_len == '0 || is_last) ? '0 : word_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rlt_unpack.sv
// Directed bench for rlt_unpack: reassembly, back-pressure, framing, reconfig and reset.
`timescale 1ns/1ps
module tb_rlt_unpack;

    localparam logic [4:0] LEN_ADDR = 5'd20;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  cfg_data = '0;
    logic [4:0]   cfg_addr = '0;
    logic         cfg_valid = 1'b0;
    logic [63:0]  str_rlt_bus = '0;
    logic         str_rlt_val = 1'b0;
    logic         str_rlt_rdy;
    logic [255:0] result_bus;
    logic         result_last;
    logic         result_val;
    logic         result_rdy = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [255:0] bus;
        logic         last;
    } word_t;

    typedef struct {
        logic [31:0] tag;
        logic        exp_last;
    } vec_t;

    word_t q[$];
    vec_t  frame_tbl[7];

    rlt_unpack dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_data    (cfg_data),
        .cfg_addr    (cfg_addr),
        .cfg_valid   (cfg_valid),
        .str_rlt_bus (str_rlt_bus),
        .str_rlt_val (str_rlt_val),
        .str_rlt_rdy (str_rlt_rdy),
        .result_bus  (result_bus),
        .result_last (result_last),
        .result_val  (result_val),
        .result_rdy  (result_rdy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && result_val && result_rdy) q.push_back({result_bus, result_last});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [31:0] tag, input int k);
        return {tag, 32'h100 + 32'(k)};
    endfunction

    function automatic logic [255:0] exp_word(input logic [31:0] tag);
        logic [255:0] w;
        for (int k = 0; k < 4; k++) w[k*64 +: 64] = mk(tag, k);
        return w;
    endfunction

    // Entered and left at posedge+1; leaves str_rlt_val high for back-to-back beats.
    task automatic send_beat(input logic [63:0] d);
        int   n = 0;
        logic took = 1'b0;
        str_rlt_bus = d;
        str_rlt_val = 1'b1;
        while (!took && n < 50) begin
            @(negedge clk);
            took = str_rlt_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: beat %h never accepted", d);
        end
    endtask

    task automatic send_word(input logic [31:0] tag);
        for (int k = 0; k < 4; k++) send_beat(mk(tag, k));
        str_rlt_val = 1'b0;
    endtask

    task automatic idle(input int n);
        str_rlt_val = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
        cfg_addr  = a;
        cfg_data  = d;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic chk_q(input string name, input int idx, input logic [31:0] tag, input logic last);
        word_t got;
        got = (idx < q.size()) ? q[idx] : '0;
        chk({name, "_bus"}, got.bus, exp_word(tag));
        chk({name, "_last"}, 256'(got.last), 256'(last));
    endtask

    initial begin
        frame_tbl[0] = '{32'hF000_0001, 1'b0};
        frame_tbl[1] = '{32'hF000_0002, 1'b0};
        frame_tbl[2] = '{32'hF000_0003, 1'b1};
        frame_tbl[3] = '{32'hF000_0004, 1'b0};
        frame_tbl[4] = '{32'hF000_0005, 1'b0};
        frame_tbl[5] = '{32'hF000_0006, 1'b1};
        frame_tbl[6] = '{32'hF000_0007, 1'b0};

        // Reset state, with a beat offered while held in reset.
        str_rlt_val = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 256'(str_rlt_rdy), 256'(0));
        chk("rst_val", 256'(result_val), 256'(0));
        chk("rst_last", 256'(result_last), 256'(0));
        chk("rst_bus", result_bus, '0);
        str_rlt_val = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reassembly with frame_len = 0.
        result_rdy = 1'b1;
        send_beat(64'h1);
        send_beat(64'h2);
        send_beat(64'h3);
        chk("asm_val_early", 256'(result_val), 256'(0));
        send_beat(64'h4);
        chk("asm_val", 256'(result_val), 256'(1));
        chk("asm_bus", result_bus, {64'h4, 64'h3, 64'h2, 64'h1});
        chk("asm_last", 256'(result_last), 256'(0));
        idle(1);
        chk("asm_val_clear", 256'(result_val), 256'(0));
        chk("asm_bus_hold", result_bus, {64'h4, 64'h3, 64'h2, 64'h1});
        idle(2);

        // Back-pressure: 8 beats offered with the output blocked.
        result_rdy = 1'b0;
        q.delete();
        for (int k = 0; k < 4; k++) send_beat(mk(32'hA0A0_0001, k));
        chk("bp_val", 256'(result_val), 256'(1));
        for (int k = 0; k < 3; k++) begin
            str_rlt_bus = mk(32'hB0B0_0002, k);
            @(negedge clk);
            chk("bp_rdy_open", 256'(str_rlt_rdy), 256'(1));
            @(posedge clk);
            #1;
        end
        str_rlt_bus = mk(32'hB0B0_0002, 3);
        repeat (3) begin
            @(negedge clk);
            chk("bp_rdy_stall", 256'(str_rlt_rdy), 256'(0));
            chk("bp_bus_stable", result_bus, exp_word(32'hA0A0_0001));
            @(posedge clk);
            #1;
        end
        result_rdy = 1'b1;
        @(negedge clk);
        chk("bp_rdy_release", 256'(str_rlt_rdy), 256'(1));
        @(posedge clk);
        #1;
        idle(3);
        chk("bp_count", 256'(q.size()), 256'(2));
        chk_q("bp_w0", 0, 32'hA0A0_0001, 1'b0);
        chk_q("bp_w1", 1, 32'hB0B0_0002, 1'b0);

        // Framing with frame_len = 3.
        q.delete();
        cfg_write(LEN_ADDR, 32'd3);
        foreach (frame_tbl[i]) send_word(frame_tbl[i].tag);
        idle(3);
        chk("frm_count", 256'(q.size()), 256'(7));
        foreach (frame_tbl[i]) chk_q($sformatf("frm_w%0d", i), i, frame_tbl[i].tag, frame_tbl[i].exp_last);

        // frame_len = 1, with a foreign cfg write in the middle of a word.
        q.delete();
        cfg_write(LEN_ADDR, 32'd1);
        send_word(32'hC000_0001);
        send_beat(mk(32'hC000_0002, 0));
        send_beat(mk(32'hC000_0002, 1));
        str_rlt_val = 1'b0;
        cfg_write(5'd3, 32'd7);
        send_beat(mk(32'hC000_0002, 2));
        send_beat(mk(32'hC000_0002, 3));
        str_rlt_val = 1'b0;
        send_word(32'hC000_0003);
        idle(3);
        chk("len1_count", 256'(q.size()), 256'(3));
        chk_q("len1_w0", 0, 32'hC000_0001, 1'b1);
        chk_q("len1_w1", 1, 32'hC000_0002, 1'b1);
        chk_q("len1_w2", 2, 32'hC000_0003, 1'b1);

        // Reconfig after a partial word discards it.
        q.delete();
        send_beat(mk(32'hDEAD_0000, 0));
        send_beat(mk(32'hDEAD_0000, 1));
        str_rlt_val = 1'b0;
        cfg_write(LEN_ADDR, 32'd2);
        send_word(32'hD000_0001);
        send_word(32'hD000_0002);
        idle(3);
        chk("rcfg_count", 256'(q.size()), 256'(2));
        chk_q("rcfg_w0", 0, 32'hD000_0001, 1'b0);
        chk_q("rcfg_w1", 1, 32'hD000_0002, 1'b1);

        // Reset with an output word pending and a 3-beat partial word.
        result_rdy = 1'b0;
        send_word(32'hE000_0001);
        for (int k = 0; k < 3; k++) send_beat(mk(32'hE000_0002, k));
        str_rlt_bus = mk(32'hE000_0002, 3);
        chk("prerst_val", 256'(result_val), 256'(1));
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_val", 256'(result_val), 256'(0));
        chk("arst_rdy", 256'(str_rlt_rdy), 256'(0));
        chk("arst_bus", result_bus, '0);
        @(posedge clk);
        #1;
        str_rlt_val = 1'b0;
        rst = 1'b1;
        result_rdy = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        send_word(32'h9000_0001);
        idle(3);
        chk("post_rst_count", 256'(q.size()), 256'(1));
        chk_q("post_rst_w0", 0, 32'h9000_0001, 1'b0);
        send_word(32'h9000_0002);
        send_word(32'h9000_0003);
        idle(3);
        chk("post_rst_count3", 256'(q.size()), 256'(3));
        chk_q("post_rst_w1", 1, 32'h9000_0002, 1'b0);
        chk_q("post_rst_w2", 2, 32'h9000_0003, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rlt_unpack.md
Name: rlt_unpack

Overview:
Host-side receiver for the coprocessor result stream. It takes the narrow result stream (str_rlt_*) that the coprocessor emits one down-converted beat at a time. It reassembles the beats into full result words of IMG_WIDTH*DEPTH_NB bits, one IMG_WIDTH pixel per depth lane, and marks frame boundaries with result_last using a frame length set over the shared cfg bus. It sits between the coprocessor result port and the host DMA/checker.

Parameters:
CFG_DWIDTH, 32, cfg bus data width.
CFG_AWIDTH, 5, cfg bus address width.
CFG_LEN_ADDR, 5'd20, cfg address of the frame-length register.
STR_RLT_WIDTH, 64, narrow stream beat width.
IMG_WIDTH, 16, pixel width per depth lane.
DEPTH_NB, 16, number of depth lanes per result word.
LEN_WIDTH, 24, frame-length and word-counter width; must not exceed CFG_DWIDTH.

Ports:
clk  in  1  single clock.
rst  in  1  asynchronous, active-low reset.
cfg_data  in  CFG_DWIDTH  cfg write data.
cfg_addr  in  CFG_AWIDTH  cfg write address.
cfg_valid  in  1  cfg write strobe.
str_rlt_bus  in  STR_RLT_WIDTH  narrow result beat.
str_rlt_val  in  1  beat valid.
str_rlt_rdy  out  1  beat ready.
result_bus  out  IMG_WIDTH*DEPTH_NB  reassembled result word.
result_last  out  1  final word of a frame.
result_val  out  1  result word valid.
result_rdy  in  1  downstream ready.

Behaviour:
- RLT_WIDTH = IMG_WIDTH*DEPTH_NB. RATIO = RLT_WIDTH/STR_RLT_WIDTH. RLT_WIDTH must be an exact multiple of STR_RLT_WIDTH and RATIO >= 2; elaboration fails otherwise.
- Beat order: the first beat of a word is bits [STR_RLT_WIDTH-1:0]. Beat k fills slice k. Each beat is LS slice first.
- A beat transfers when str_rlt_val and str_rlt_rdy are both high. A word transfers when result_val and result_rdy are both high.
- State:
  - beat_cnt, 0..RATIO-1.
  - Assembly register holding RATIO-1 slices.
  - Output register: result_bus, result_val, result_last.
  - frame_len (LEN_WIDTH).
  - word_cnt (LEN_WIDTH).
- str_rlt_rdy = rst_deasserted AND NOT (beat_cnt==RATIO-1 AND result_val AND NOT result_rdy). Only the closing beat stalls, and only while the output register is occupied and not draining.
- Accepting a non-final beat: store the slice and increment beat_cnt.
- Accepting the final beat (beat_cnt==RATIO-1):
  - Load result_bus = {beat, assembly slices}, set result_val, and reset beat_cnt to 0.
  - Set result_last = (frame_len != 0 AND word_cnt == frame_len-1).
  - word_cnt increments, or wraps to 0 when result_last is being set.
- Latency: result_val is high the cycle after the final beat is accepted.
- Throughput: one beat per cycle with no bubbles while result_rdy stays high.
- A word handshake with no new word loading clears result_val and result_last. result_bus holds its value.
- Simultaneous word handshake and final-beat load: the new word loads and result_val stays high.
- frame_len == 0: result_last is never asserted and word_cnt stays 0.
- cfg write (cfg_valid AND cfg_addr==CFG_LEN_ADDR):
  - frame_len <= cfg_data[LEN_WIDTH-1:0].
  - word_cnt <= 0, beat_cnt <= 0, and the partial word is discarded.
  - The occupied output register is untouched.
  - If a final beat is accepted in the same cycle, the cfg write wins and the beat is dropped.
- Writes to other cfg addresses are ignored.
- Reset (async assert, sync release):
  - result_val=0, result_last=0, result_bus=0.
  - beat_cnt=0, word_cnt=0, frame_len=0.
  - str_rlt_rdy=0 while reset is asserted.
  - Reset mid-word discards the partial word.
- result_bus is stable while result_val is high and result_rdy is low.

Decomposition:
- Shared package cnn_pkg holds:
  - The cfg address constants, including CFG_LEN_ADDR alongside the existing layer/kernel/image registers.
  - A ratio helper function returning RLT_WIDTH/STR_RLT_WIDTH.
- One natural sub-module: rlt_assemble. It holds the beat counter and the assembly register, emits a {word, word_val} pulse, and exposes the stall input.
- rlt_unpack wraps rlt_assemble with the output register, frame counter and cfg decode.

Test Plan:
- Reassembly: frame_len=0. Send 4 beats 0x...01, 0x...02, 0x...03, 0x...04 (64-bit, default params) with result_rdy=1. Expect one result_val pulse one cycle after beat 4, result_bus = {beat4, beat3, beat2, beat1}, result_last=0.
- Back-pressure: result_rdy=0 with 8 beats offered back-to-back.
  - Expect the first word held stable.
  - Expect str_rlt_rdy=1 for beats 5-7 and 0 at beat 8 until result_rdy=1.
  - Then both words arrive in order with no loss or duplication.
- Framing: cfg write 3 to CFG_LEN_ADDR, then stream 7 words. Expect result_last on words 3 and 6 only, and word_cnt wrapped after word 3.
- Length 1: frame_len=1. Expect result_last on every word. A cfg write to a different address mid-stream has no effect.
- Mid-frame reconfig: after 2 beats of word 1, cfg write frame_len=2.
  - The partial word is discarded; the next 4 beats form word 1 of the new frame.
  - result_last is set on the second new word.
- Reset mid-operation: assert rst low after 3 beats with an output word pending.
  - result_val and str_rlt_rdy drop immediately.
  - After release, 4 fresh beats produce exactly one correct word and frame_len reads as 0 (no last).
